// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC and issues one instruction-memory read at a time.
// It presents each fetched word to decode under a valid/stall handshake and squashes wrong-path words after a redirect.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        discard;
  logic [31:0] target;

  assign target         = redirect_pc & ~32'h3;
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_addr      = pc;
  assign flush          = redirect_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= target;
            // A request accepted in the redirect cycle carried the old PC, so its word is wrong-path.
            if (imem_req_ready) begin
              state   <= S_WAIT;
              discard <= 1'b1;
            end
          end else if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= target;
            if (imem_resp_valid) begin
              state   <= S_REQ;
              discard <= 1'b0;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_instr <= imem_resp_data;
              pc       <= pc + 32'd4;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc       <= target;
            if_valid <= 1'b0;
            state    <= S_REQ;
          end else if (!stall) begin
            if_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: begin
          state    <= S_REQ;
          if_valid <= 1'b0;
          discard  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against a transaction-level model
// that tracks the expected fetch PC, the in-flight request, and the word offered to decode.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;

  fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flush(flush)
  );

  // Second instance starting at the top of the address space, wired to an always-ready 1-cycle memory.
  logic        req2_valid, resp2_valid, if2_valid, flush2;
  logic        ready2 = 1'b1;
  logic        redir2 = 1'b0;
  logic        stall2 = 1'b0;
  logic [31:0] addr2, if2_pc, if2_instr;
  logic [31:0] data2 = 32'h0;
  logic [31:0] rpc2 = 32'h0;

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req2_valid), .imem_req_ready(ready2), .imem_addr(addr2),
    .imem_resp_valid(resp2_valid), .imem_resp_data(data2),
    .redirect_valid(redir2), .redirect_pc(rpc2), .stall(stall2),
    .if_valid(if2_valid), .if_pc(if2_pc), .if_instr(if2_instr), .flush(flush2)
  );

  always @(posedge clk) resp2_valid <= req2_valid && !rst;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Model: expected next fetch PC, request in flight, whether it is wrong-path, word offered to decode.
  logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_instr = 32'h0;
  logic        m_out = 1'b0, m_sq = 1'b0, m_v = 1'b0;
  bit          started = 0;

  task automatic model_step();
    logic req, accept, resp;
    if (rst) begin
      m_pc = 32'h4000_0000; m_out = 0; m_sq = 0; m_v = 0; m_ipc = 0; m_instr = 0;
    end else begin
      req    = !m_out && !m_v;
      accept = req && imem_req_ready;
      resp   = m_out && imem_resp_valid;
      if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_v  = 0;
        if (accept) begin m_out = 1; m_sq = 1; end
        else if (resp) begin m_out = 0; m_sq = 0; end
        else if (m_out) m_sq = 1;
      end else begin
        if (m_v && !stall) m_v = 0;
        if (accept) m_out = 1;
        if (resp) begin
          m_out = 0;
          if (m_sq) m_sq = 0;
          else begin
            m_v = 1; m_ipc = m_pc; m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  endtask

  // Memory model and stimulus knobs.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit          acc_s = 0;
  logic [31:0] addr_s = 32'h0;
  bit          rnd = 0, inj_stale = 0;
  bit          d_rst = 1, d_ready = 0, d_stall = 0, d_redir = 0;
  logic [31:0] d_rpc = 32'h0;
  int          lat_cfg = 1;
  logic [31:0] log_a [8];
  int          log_n = 0;
  logic [31:0] log2 [2];
  int          log2_n = 0;

  task automatic step();
    @(posedge clk);
    model_step();
    if (rst) mem_pend = 0;
    else begin
      if (imem_resp_valid) mem_pend = 0;
      if (acc_s) begin
        mem_pend = 1;
        mem_cnt  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
        mem_addr = addr_s;
      end
    end
    #1;
    if (rnd) begin
      rst            = ($urandom_range(0, 199) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = $urandom_range(0, 1) != 0;
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end else begin
      rst = d_rst; imem_req_ready = d_ready; stall = d_stall;
      redirect_valid = d_redir; redirect_pc = d_rpc;
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_pend && !rst && mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
      end
    end
    if (inj_stale) imem_resp_valid = 1'b1;
    #1;
    acc_s  = imem_req_valid && imem_req_ready;
    addr_s = imem_addr;
    if (acc_s && log_n < 8) begin log_a[log_n] = addr_s; log_n++; end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("req_valid", imem_req_valid, !rst && !m_out && !m_v);
      if (!rst && !m_out && !m_v) chk("req_addr", imem_addr, m_pc);
      chk("flush", flush, redirect_valid && !rst);
      chk("if_valid", if_valid, m_v);
      if (m_v) begin
        chk("if_pc", if_pc, m_ipc);
        chk("if_instr", if_instr, m_instr);
      end
      if (req2_valid === 1'b1 && log2_n < 2) begin log2[log2_n] = addr2; log2_n++; end
    end
  end

  task automatic wait_acc(input string name);
    int n = 0;
    while (!acc_s && n < 30) begin step(); n++; end
    if (!acc_s) chk(name, 32'd0, 32'd1);
  endtask

  task automatic wait_ifv(input string name);
    int n = 0;
    while (if_valid !== 1'b1 && n < 30) begin step(); n++; end
    if (if_valid !== 1'b1) chk(name, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] sv_pc, sv_instr;
    bit seen;
    int n;
    for (int i = 0; i < 8; i++) log_a[i] = 32'h0;
    log2[0] = 32'h0; log2[1] = 32'h0;

    // 1: two reset cycles, always-ready 1-cycle memory.
    d_rst = 1; d_ready = 1; lat_cfg = 1;
    step(); started = 1;
    d_rst = 0; log_n = 0;
    step();
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_flush", flush, 1'b0);
    chk("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_addr, 32'h4000_0000);
    repeat (10) step();
    chk("t1_addr0", log_a[0], 32'h4000_0000);
    chk("t1_addr1", log_a[1], 32'h4000_0004);
    chk("t1_addr2", log_a[2], 32'h4000_0008);

    // 2: hold a word under stall for five cycles.
    d_stall = 1;
    wait_ifv("t2_timeout");
    sv_pc = if_pc; sv_instr = if_instr;
    chk("t2_instr_mem", sv_instr, mem_word(sv_pc));
    repeat (5) begin
      step();
      chk("t2_hold_valid", if_valid, 1'b1);
      chk("t2_hold_pc", if_pc, sv_pc);
      chk("t2_hold_instr", if_instr, sv_instr);
      chk("t2_no_req", imem_req_valid, 1'b0);
    end
    d_stall = 0;
    step(); step();
    chk("t2_consumed", if_valid, 1'b0);
    chk("t2_next_req", imem_req_valid, 1'b1);
    chk("t2_next_addr", imem_addr, sv_pc + 32'd4);

    // 3: redirect while waiting; the late word is dropped.
    lat_cfg = 3;
    wait_acc("t3_timeout");
    d_redir = 1; d_rpc = 32'h4000_0103;
    step();
    chk("t3_flush", flush, 1'b1);
    d_redir = 0;
    seen = 0; n = 0;
    step();
    while (imem_req_valid !== 1'b1 && n < 20) begin
      if (if_valid === 1'b1) seen = 1;
      step(); n++;
    end
    chk("t3_req", imem_req_valid, 1'b1);
    chk("t3_addr", imem_addr, 32'h4000_0100);
    chk("t3_no_word", 32'(seen), 32'd0);

    // 4a: redirect coincides with the response.
    lat_cfg = 2;
    wait_acc("t4a_timeout");
    step();
    d_redir = 1; d_rpc = 32'h4000_0200;
    step();
    chk("t4a_flush", flush, 1'b1);
    d_redir = 0;
    step();
    chk("t4a_if_valid", if_valid, 1'b0);
    chk("t4a_req", imem_req_valid, 1'b1);
    chk("t4a_addr", imem_addr, 32'h4000_0200);

    // 4b: redirect while holding a stalled word.
    lat_cfg = 1; d_stall = 1;
    wait_ifv("t4b_timeout");
    d_redir = 1; d_rpc = 32'h4000_0301;
    step();
    chk("t4b_flush", flush, 1'b1);
    d_redir = 0;
    step();
    chk("t4b_if_valid", if_valid, 1'b0);
    chk("t4b_addr", imem_addr, 32'h4000_0300);
    d_stall = 0;

    // 6: reset in WAIT, then a stale response arrives while idle.
    lat_cfg = 3;
    wait_acc("t6_timeout");
    step();
    d_rst = 1; d_redir = 1; d_rpc = 32'h1234_5678;
    step();
    chk("t6_rst_flush", flush, 1'b0);
    chk("t6_rst_req", imem_req_valid, 1'b0);
    d_rst = 0; d_redir = 0; d_ready = 0; inj_stale = 1;
    step();
    chk("t6_if_valid", if_valid, 1'b0);
    chk("t6_req_addr", imem_addr, 32'h4000_0000);
    inj_stale = 0; d_ready = 1; lat_cfg = 1;
    wait_ifv("t6_timeout2");
    chk("t6_pc", if_pc, 32'h4000_0000);
    chk("t6_instr", if_instr, mem_word(32'h4000_0000));

    // 5: wrap of the top-of-memory instance.
    chk("t5_count", 32'(log2_n), 32'd2);
    chk("t5_addr0", log2[0], 32'hFFFF_FFFC);
    chk("t5_addr1", log2[1], 32'h0000_0000);

    // Randomized traffic checked every cycle by the compare process.
    rnd = 1; lat_cfg = 0;
    repeat (4000) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
